// File: rtl/nco_pulse_seq_pkg.sv
// Shared types and default sizes for the NCO pulse sequencer.
package nco_pulse_seq_pkg;

  localparam int N_DEF          = 22;
  localparam int LEN_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_LOAD,
    ST_RUN
  } state_e;

  typedef struct packed {
    logic [N_DEF-1:0]     ftw;
    logic [LEN_W_DEF-1:0] len;
    logic                 clr;
  } cmd_t;

  function automatic int cmd_bits(input int n, input int len_w);
    return n + len_w + 1;
  endfunction

endpackage

// File: rtl/nco_cmd_fifo.sv
// Synchronous command FIFO with flush; a full FIFO may push and pop in one cycle.
module nco_cmd_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][W-1:0] mem_q, mem_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;
  logic                    do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: rtl/nco_pulse_seq.sv
// Pulse command sequencer driving NCO clear / FTW load / phase advance.
// NCO_PULSE_SEQ_FIFO_EN selects a FIFO_DEPTH command FIFO instead of a single holding register.
module nco_pulse_seq
  import nco_pulse_seq_pkg::*;
#(
  parameter int N          = N_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [N-1:0]     cmd_ftw,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_clr,
  input  logic             abort,
  output logic             nco_clr,
  output logic             nco_ftw_wr_en,
  output logic [N-1:0]     nco_ftw,
  output logic             nco_phase_wr_en,
  output logic             busy,
  output logic             done
);

  typedef struct packed {
    logic [N-1:0]     ftw;
    logic [LEN_W-1:0] len;
    logic             clr;
  } cmd_s;

  localparam int CW = $bits(cmd_s);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 2");
  end

  state_e           state_q, state_d;
  cmd_s             cur_q, cur_d;
  cmd_s             in_cmd, head;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     ftw_q, ftw_d;
  logic             live_q;
  logic             buf_empty, buf_full;
  logic             push, pop;

  // live_q keeps cmd_ready low until the first edge after reset release
  assign in_cmd    = {cmd_ftw, cmd_len, cmd_clr};
  assign cmd_ready = live_q && !buf_full && !abort;
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == ST_IDLE) && !buf_empty && !abort;

`ifdef NCO_PULSE_SEQ_FIFO_EN
  nco_cmd_fifo #(
    .W     (CW),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (abort),
    .push  (push),
    .pop   (pop),
    .din   (in_cmd),
    .dout  (head),
    .empty (buf_empty),
    .full  (buf_full)
  );
`else
  logic hold_vld_q, hold_vld_d;
  cmd_s hold_q, hold_d;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    if (pop) hold_vld_d = 1'b0;
    if (push) begin
      hold_vld_d = 1'b1;
      hold_d     = in_cmd;
    end
    if (abort) hold_vld_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_vld_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign buf_empty = !hold_vld_q;
  assign buf_full  = hold_vld_q;
  assign head      = hold_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cur_q   <= '0;
      cnt_q   <= '0;
      ftw_q   <= '0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      cnt_q   <= cnt_d;
      ftw_q   <= ftw_d;
      live_q  <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (pop) state_d = head.clr ? ST_CLR : ST_LOAD;
      ST_CLR:  state_d = ST_LOAD;
      ST_LOAD: state_d = (cnt_q == '0) ? ST_IDLE : ST_RUN;
      ST_RUN:  if (cnt_q == LEN_W'(1)) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // FTW and count are captured on entry to LOAD so nco_ftw only moves with a load
  always_comb begin
    cur_d = pop ? head : cur_q;
    cnt_d = cnt_q;
    ftw_d = ftw_q;
    if (state_d == ST_LOAD) begin
      cnt_d = cur_d.len;
      ftw_d = cur_d.ftw;
    end else if (state_q == ST_RUN && cnt_q != '0) begin
      cnt_d = cnt_q - LEN_W'(1);
    end
  end

  always_comb begin
    nco_clr         = (state_q == ST_CLR);
    nco_ftw_wr_en   = (state_q == ST_LOAD);
    nco_phase_wr_en = (state_q == ST_RUN);
    done            = ((state_q == ST_LOAD) && (cnt_q == '0)) ||
                      ((state_q == ST_RUN)  && (cnt_q == LEN_W'(1)));
    busy            = (state_q != ST_IDLE) || !buf_empty;
    nco_ftw         = ftw_q;
  end

endmodule
